data_request_controller: RTL
============================

Name: data_request_controller

Overview:
- Sequences the ex-stage data-memory access onto the sram-like data bus (request/address_ready, then data_ready).
- Registers and holds each request until it is accepted, and back-pressures ex through ex_ready_go.
- Tracks up to MAX_OUTSTANDING accepted transactions and returns read data to the io stage in order.
- Drops the responses of transactions that a wb exception or eret flush has killed.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions; allowed range 1..4.

Ports:
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- ex_valid  input  1  ex stage holds a valid instruction
- ex_memory_access  input  1  that instruction is a load or store
- ex_write  input  1  1 = store, 0 = load
- ex_size  input  2  0 = byte, 1 = half, 2 = word
- ex_address  input  32  access address
- ex_write_data  input  32  store data, already lane-aligned
- ex_write_strobe  input  4  byte enables
- ex_advance  input  1  ex instruction moves to io this cycle (ex_valid && io_allow_in)
- flush  input  1  wb exception_valid or eret_flush
- ex_ready_go  output  1  the memory access of the current ex instruction is accepted (or none is needed)
- data_ram_request  output  1  bus request
- data_ram_write  output  1  bus write
- data_ram_size  output  2  bus size
- data_ram_address  output  32  bus address
- data_ram_write_data  output  32  bus write data
- data_ram_write_strobe  output  4  bus strobes
- data_ram_address_ready  input  1  address handshake
- data_ram_data_ready  input  1  response strobe
- data_ram_read_data  input  32  response data
- io_response_valid  output  1  live (not cancelled) response this cycle
- io_response_data  output  32  response data, equals data_ram_read_data
- outstanding_count  output  3  accepted, unanswered transactions

Behaviour:
- Reset values: state IDLE; all registered payload 0; accepted 0; outstanding 0; cancel FIFO pointers 0; data_ram_request 0; ex_ready_go 0 while ex_memory_access is 1.
- FSM has two states.
  - IDLE to REQ when ex_valid & ex_memory_access & !accepted & !flush & outstanding < MAX_OUTSTANDING.
  - On that transition the ex_* payload is captured into registers; data_ram_* drive only from these registers.
  - REQ: data_ram_request = 1 and the payload is held stable until data_ram_address_ready = 1.
  - The handshake cycle goes REQ to IDLE, sets accepted, outstanding +1, and pushes a cancel bit.
- Request latency: request is asserted on the cycle after ex presents the access. Minimum ex occupancy for a memory op is 2 cycles.
- A request is never withdrawn once asserted, even on flush.
  - Flush while in REQ sets cancel_pending; the transaction completes its handshake with its cancel bit = 1.
  - cancel_pending clears on the handshake.
- ex_ready_go = !ex_memory_access | accepted | (state==REQ & data_ram_address_ready & !cancel_pending & !flush).
- accepted clears on ex_advance or flush.
  - If ex_advance and a new capture happen in the same cycle, the capture wins and accepted stays 0 until its handshake.
- Cancel FIFO:
  - Depth MAX_OUTSTANDING, one bit per entry, in order.
  - Pushed on handshake, popped on data_ram_data_ready.
  - Flush sets the cancel bit of every occupied entry, including an entry pushed in the same cycle.
  - Simultaneous push and pop: outstanding unchanged, both pointers advance, pointers wrap modulo the depth.
- io_response_valid = data_ram_data_ready & outstanding != 0 & !head_cancel & !flush. io_response_data = data_ram_read_data, unregistered.
- Cancelled responses are consumed silently: the pop happens and io sees nothing.
- data_ram_data_ready while outstanding == 0 is a protocol error: ignored, no pop, no underflow.
- Full condition: outstanding == MAX_OUTSTANDING blocks IDLE to REQ. A pop in the same cycle does not unblock it (the check is registered-count only).
- Reset mid-transaction: all state returns to reset values immediately. Responses in flight after reset are ignored by the protocol-error rule.
- Non-memory ex instructions never touch the bus.

Test Plan:
1. Load word at 0x0000_1004, address_ready held 1, data 0xDEAD_BEEF two cycles after the handshake:
   - request rises 1 cycle after ex_valid, with size 2 and address 0x1004;
   - ex_ready_go = 1 in the handshake cycle;
   - io_response_valid = 1 with 0xDEAD_BEEF; outstanding returns to 0.
2. Store byte, strobe 4'b0100, address_ready withheld for 5 cycles:
   - request and payload stay constant for all 5 cycles;
   - ex_ready_go stays 0 until the handshake; no response is expected for the store.
3. Flush asserted in cycle 2 of a held load request:
   - request stays 1 until address_ready;
   - the later data_ready produces io_response_valid = 0; outstanding ends at 0.
4. MAX_OUTSTANDING = 2, three back-to-back loads, responses withheld:
   - third request is not asserted until the first data_ready arrives;
   - responses come back in order, A then B then C.
5. Two outstanding loads, flush asserted, then two data_ready pulses:
   - both responses are dropped (io_response_valid = 0);
   - a new load issued afterwards returns valid data.
6. Reset asserted while in REQ with outstanding = 1:
   - next cycle request = 0, outstanding = 0;
   - a stray data_ready is ignored and the count stays 0.

Source files
------------

// File: rtl/data_ram_if.sv
// Sram-like data bus between the data request controller (master) and data memory (slave).
// The request/address_ready handshake accepts a transaction; data_ready returns its response.
interface data_ram_if;
    logic        data_ram_request;
    logic        data_ram_write;
    logic [1:0]  data_ram_size;
    logic [31:0] data_ram_address;
    logic [31:0] data_ram_write_data;
    logic [3:0]  data_ram_write_strobe;
    logic        data_ram_address_ready;
    logic        data_ram_data_ready;
    logic [31:0] data_ram_read_data;

    modport master (
        output data_ram_request,
        output data_ram_write,
        output data_ram_size,
        output data_ram_address,
        output data_ram_write_data,
        output data_ram_write_strobe,
        input  data_ram_address_ready,
        input  data_ram_data_ready,
        input  data_ram_read_data
    );

    modport slave (
        input  data_ram_request,
        input  data_ram_write,
        input  data_ram_size,
        input  data_ram_address,
        input  data_ram_write_data,
        input  data_ram_write_strobe,
        output data_ram_address_ready,
        output data_ram_data_ready,
        output data_ram_read_data
    );
endinterface

// File: rtl/data_request_controller.sv
// Issues ex-stage loads/stores on the sram-like data bus, tracks outstanding transactions and
// returns in-order read data to io, silently dropping responses of flushed transactions.
module data_request_controller #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_memory_access,
    input  logic             ex_write,
    input  logic [1:0]       ex_size,
    input  logic [31:0]      ex_address,
    input  logic [31:0]      ex_write_data,
    input  logic [3:0]       ex_write_strobe,
    input  logic             ex_advance,
    input  logic             flush,
    output logic             ex_ready_go,
    data_ram_if.master       data_ram,
    output logic             io_response_valid,
    output logic [31:0]      io_response_data,
    output logic [2:0]       outstanding_count
);

    localparam int unsigned     PtrW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0]      MaxCount = 3'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e                     state_q, state_d;
    logic                       write_q, write_d;
    logic [1:0]                 size_q, size_d;
    logic [31:0]                address_q, address_d;
    logic [31:0]                write_data_q, write_data_d;
    logic [3:0]                 write_strobe_q, write_strobe_d;
    logic                       accepted_q, accepted_d;
    logic                       cancel_pending_q, cancel_pending_d;
    logic [2:0]                 outstanding_q, outstanding_d;
    logic [MAX_OUTSTANDING-1:0] cancel_q, cancel_d;
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;

    logic capture;
    logic handshake;
    logic handshake_live;
    logic pop;
    logic head_cancel;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Full check uses the registered count only, so a same-cycle pop never unblocks a capture.
    assign capture = (state_q == StIdle) & ex_valid & ex_memory_access & ~accepted_q & ~flush &
                     (outstanding_q < MaxCount);
    assign handshake      = (state_q == StReq) & data_ram.data_ram_address_ready;
    assign handshake_live = handshake & ~cancel_pending_q & ~flush;
    assign pop            = data_ram.data_ram_data_ready & (outstanding_q != 3'd0);
    assign head_cancel    = cancel_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= StIdle;
            write_q          <= 1'b0;
            size_q           <= 2'd0;
            address_q        <= 32'd0;
            write_data_q     <= 32'd0;
            write_strobe_q   <= 4'd0;
            accepted_q       <= 1'b0;
            cancel_pending_q <= 1'b0;
            outstanding_q    <= 3'd0;
            cancel_q         <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            size_q           <= size_d;
            address_q        <= address_d;
            write_data_q     <= write_data_d;
            write_strobe_q   <= write_strobe_d;
            accepted_q       <= accepted_d;
            cancel_pending_q <= cancel_pending_d;
            outstanding_q    <= outstanding_d;
            cancel_q         <= cancel_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (capture) state_d = StReq;
            StReq:   if (data_ram.data_ram_address_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        write_d        = write_q;
        size_d         = size_q;
        address_d      = address_q;
        write_data_d   = write_data_q;
        write_strobe_d = write_strobe_q;
        if (capture) begin
            write_d        = ex_write;
            size_d         = ex_size;
            address_d      = ex_address;
            write_data_d   = ex_write_data;
            write_strobe_d = ex_write_strobe;
        end

        // A flushed transaction completes its handshake but never counts as accepted for ex.
        if (flush || ex_advance) begin
            accepted_d = 1'b0;
        end else if (handshake_live) begin
            accepted_d = 1'b1;
        end else begin
            accepted_d = accepted_q;
        end

        if (handshake) begin
            cancel_pending_d = 1'b0;
        end else if ((state_q == StReq) && flush) begin
            cancel_pending_d = 1'b1;
        end else begin
            cancel_pending_d = cancel_pending_q;
        end

        outstanding_d = outstanding_q + {2'b00, handshake} - {2'b00, pop};
        wr_ptr_d      = handshake ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        // Free entries are rewritten on push, so marking the whole FIFO on flush is safe.
        cancel_d = cancel_q;
        if (handshake) cancel_d[wr_ptr_q] = cancel_pending_q;
        if (flush) cancel_d = '1;
    end

    always_comb begin
        data_ram.data_ram_request      = (state_q == StReq);
        data_ram.data_ram_write        = write_q;
        data_ram.data_ram_size         = size_q;
        data_ram.data_ram_address      = address_q;
        data_ram.data_ram_write_data   = write_data_q;
        data_ram.data_ram_write_strobe = write_strobe_q;
        ex_ready_go       = ~ex_memory_access | accepted_q | handshake_live;
        io_response_valid = pop & ~head_cancel & ~flush;
        io_response_data  = data_ram.data_ram_read_data;
        outstanding_count = outstanding_q;
    end

endmodule
